demux_lane_deserializer: RTL and testbench

//   Accepts a serial bit stream and steers each bit round-robin across 4 lanes with a

---
 rtl/demux_lane_pkg.sv | 13 +
 rtl/demux_lane_deserializer_lane_steer.sv | 22 ++
 rtl/demux_lane_deserializer.sv | 143 ++++++++++++++
 tb/tb_demux_lane_deserializer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_lane_pkg.sv
// Shared constants and FSM state type for the serial-to-parallel lane demux.
package demux_lane_pkg;

  localparam int unsigned NUM_LANES  = 4;
  localparam int unsigned LANE_SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/demux_lane_deserializer_lane_steer.sv
// Combinational 1-to-NUM_LANES steering of an accepted serial bit.
module lane_steer
  import demux_lane_pkg::*;
(
  input  logic                  in_bit,
  input  logic                  accept,
  input  logic [LANE_SEL_W-1:0] lane_sel,
  output logic [NUM_LANES-1:0]  lane_en_c,
  output logic [NUM_LANES-1:0]  lane_bit_c
);

  // Raise the write enable and data for the selected lane only on an accept
  always_comb begin
    lane_en_c  = '0;
    lane_bit_c = '0;
    if (accept) begin
      lane_en_c[lane_sel]  = 1'b1;
      lane_bit_c[lane_sel] = in_bit;
    end
  end

endmodule

// File: rtl/demux_lane_deserializer.sv
// Serial bit stream deserializer: round-robin steering into 4 lanes of WIDTH
// bits each, one parallel word presented under valid/ready.
module demux_lane_deserializer
  import demux_lane_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_bit,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [NUM_LANES*WIDTH-1:0] out_data,
  output logic                       out_valid,
  output logic                       out_partial,
  input  logic                       out_ready,
  output logic [LANE_SEL_W-1:0]      lane_sel
);

  localparam int unsigned TOTAL_BITS = NUM_LANES * WIDTH;
  localparam int unsigned CNT_W      = $clog2(TOTAL_BITS) + 1;
  localparam int unsigned POS_W      = $clog2(WIDTH);

  state_t                     state_q;
  state_t                     state_d;
  logic [CNT_W-1:0]           cnt_q;
  logic [WIDTH-1:0]           lane_q [NUM_LANES];
  logic [WIDTH-1:0]           lane_d [NUM_LANES];
  logic [NUM_LANES*WIDTH-1:0] word_c;
  logic [NUM_LANES-1:0]       lane_en_c;
  logic [NUM_LANES-1:0]       lane_bit_c;
  logic [POS_W-1:0]           pos_c;
  logic                       accept_c;
  logic                       take_c;
  logic                       last_c;
  logic                       load_c;
  logic                       partial_c;
  logic                       clear_c;

  assign accept_c = in_valid & in_ready;
  assign take_c   = out_valid & out_ready;
  assign last_c   = (cnt_q == CNT_W'(TOTAL_BITS - 1));
  // Bit k lands at position k / NUM_LANES within its lane
  assign pos_c    = cnt_q[LANE_SEL_W +: POS_W];

  lane_steer u_lane_steer (
    .in_bit     (in_bit),
    .accept     (accept_c),
    .lane_sel   (lane_sel),
    .lane_en_c  (lane_en_c),
    .lane_bit_c (lane_bit_c)
  );

  // Next lane contents including this cycle's bit, and the packed word view
  always_comb begin
    word_c = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_d[l] = lane_q[l];
      if (lane_en_c[l]) begin
        lane_d[l][pos_c] = lane_bit_c[l];
      end
      word_c[l*WIDTH +: WIDTH] = lane_d[l];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept_c) state_d = COLLECT;
      COLLECT: if ((accept_c && last_c) || flush) state_d = HOLD;
      HOLD:    if (take_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM control outputs: close a word (full or flushed) and clear on take
  always_comb begin
    load_c    = 1'b0;
    partial_c = 1'b0;
    clear_c   = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (accept_c && last_c) begin
          load_c = 1'b1;
        end else if (flush) begin
          load_c    = 1'b1;
          partial_c = 1'b1;
        end
      end
      HOLD:    clear_c = take_c;
      default: ;
    endcase
  end

  // Bit counter, lane select and lane storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      lane_sel <= '0;
      for (int l = 0; l < NUM_LANES; l++) lane_q[l] <= '0;
    end else if (clear_c) begin
      cnt_q    <= '0;
      lane_sel <= '0;
      for (int l = 0; l < NUM_LANES; l++) lane_q[l] <= '0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) lane_q[l] <= lane_d[l];
      if (accept_c) begin
        cnt_q    <= cnt_q + CNT_W'(1);
        lane_sel <= lane_sel + LANE_SEL_W'(1);
      end
    end
  end

  // Output word register and handshake flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data    <= '0;
      out_partial <= 1'b0;
      out_valid   <= 1'b0;
      in_ready    <= 1'b1;
    end else if (load_c) begin
      out_data    <= word_c;
      out_partial <= partial_c;
      out_valid   <= 1'b1;
      in_ready    <= 1'b0;
    end else if (clear_c) begin
      out_valid   <= 1'b0;
      in_ready    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_lane_deserializer.sv
// Self-checking bench for demux_lane_deserializer (WIDTH = 8).
module tb_demux_lane_deserializer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DW    = 4 * WIDTH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_bit = 1'b0;
  logic          in_valid = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b1;
  logic          in_ready;
  logic          out_valid;
  logic          out_partial;
  logic [DW-1:0] out_data;
  logic [1:0]    lane_sel;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          partial;
  } exp_t;

  typedef struct {
    logic [DW-1:0] v;
    int            n;
    bit            rnd;
    bit            flush_last;
    bit            flush_after;
    int            hold;
    logic [DW-1:0] exp_data;
    bit            exp_partial;
    bit            use_model;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  demux_lane_deserializer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_bit      (in_bit),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .flush       (flush),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_partial (out_partial),
    .out_ready   (out_ready),
    .lane_sel    (lane_sel)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference mapping: stream bit k -> lane k%4, position k/4
  function automatic logic [DW-1:0] model(input logic [DW-1:0] v, input int n);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[(k % 4) * WIDTH + k / 4] = v[k];
    return r;
  endfunction

  // Drive n bits of v; inputs change 1 time unit after the rising edge
  task automatic send_bits(input logic [DW-1:0] v, input int n, input bit rnd, input bit flush_last);
    int k;
    int guard;
    bit acc;
    k = 0;
    guard = 0;
    while (k < n && guard < 20 * DW) begin
      in_bit   = v[k];
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      flush    = flush_last && (k == n - 1) && in_valid;
      acc      = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) k++;
      guard++;
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    if (k < n) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got %0d accepts, expected %0d", k, n);
    end
  endtask

  // Scoreboard consumer: compare every taken word against the queue head
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%0h, expected no word", out_data);
      end else begin
        e = sb.pop_front();
        check("word_data", out_data, e.data);
        check("word_partial", DW'(out_partial), DW'(e.partial));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   waited;

    //            v             n  rnd fl  fa hold exp_data      p  model
    vecs[0] = '{32'h0000000F, 32, 0, 0, 0, 0, 32'h01010101, 0, 0};
    vecs[1] = '{32'h00000010, 32, 0, 0, 0, 0, 32'h00000002, 0, 0};
    vecs[2] = '{32'h80000000, 32, 0, 0, 0, 0, 32'h80000000, 0, 0};
    vecs[3] = '{32'h0000003F,  6, 0, 0, 1, 0, 32'h01010303, 1, 0};
    vecs[4] = '{32'hFFFFFFFF, 32, 0, 0, 0, 5, 32'hFFFFFFFF, 0, 0};
    vecs[5] = '{32'h12345678, 32, 1, 0, 0, 0, 32'h00000000, 0, 1};
    vecs[6] = '{32'hFFFFFFFF, 32, 0, 1, 0, 0, 32'hFFFFFFFF, 0, 0};
    vecs[7] = '{32'h0000001F,  5, 0, 1, 0, 0, 32'h01010103, 1, 0};

    // Reset state, checked while reset is still asserted
    #12;
    check("rst_out_data", out_data, '0);
    check("rst_out_valid", DW'(out_valid), DW'(1'b0));
    check("rst_out_partial", DW'(out_partial), DW'(1'b0));
    check("rst_lane_sel", DW'(lane_sel), DW'(2'd0));
    check("rst_in_ready", DW'(in_ready), DW'(1'b1));
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      e.data    = vecs[i].use_model ? model(vecs[i].v, vecs[i].n) : vecs[i].exp_data;
      e.partial = vecs[i].exp_partial;
      sb.push_back(e);
      out_ready = (vecs[i].hold == 0);
      send_bits(vecs[i].v, vecs[i].n, vecs[i].rnd, vecs[i].flush_last);
      if (vecs[i].flush_after) begin
        check("lane_sel_before_flush", DW'(lane_sel), DW'(vecs[i].n % 4));
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
      end
      check("valid_after_word", DW'(out_valid), DW'(1'b1));
      for (int h = 0; h < vecs[i].hold; h++) begin
        in_valid = 1'b1;
        in_bit   = 1'b0;
        check("hold_valid", DW'(out_valid), DW'(1'b1));
        check("hold_in_ready", DW'(in_ready), DW'(1'b0));
        check("hold_data", out_data, e.data);
        check("hold_lane_sel", DW'(lane_sel), DW'(2'd0));
        @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("valid_one_cycle", DW'(out_valid), DW'(1'b0));
      check("ready_after_take", DW'(in_ready), DW'(1'b1));
      check("lane_sel_after_take", DW'(lane_sel), DW'(2'd0));
    end

    // flush while idle must not produce a word
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("idle_flush_no_valid", DW'(out_valid), DW'(1'b0));
      @(posedge clk); #1;
    end
    check("idle_flush_in_ready", DW'(in_ready), DW'(1'b1));

    // Asynchronous reset mid-word discards partial data
    send_bits(32'h000003FF, 10, 1'b0, 1'b0);
    check("mid_lane_sel", DW'(lane_sel), DW'(2'd2));
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_data", out_data, '0);
    check("async_rst_valid", DW'(out_valid), DW'(1'b0));
    check("async_rst_lane_sel", DW'(lane_sel), DW'(2'd0));
    check("async_rst_in_ready", DW'(in_ready), DW'(1'b1));
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    e.data    = 32'h01010101;
    e.partial = 1'b0;
    sb.push_back(e);
    send_bits(32'h0000000F, 32, 1'b0, 1'b0);
    check("post_rst_valid", DW'(out_valid), DW'(1'b1));
    @(posedge clk); #1;
    check("post_rst_taken", DW'(out_valid), DW'(1'b0));

    // Drain the scoreboard within a bounded wait
    waited = 0;
    while (sb.size() != 0 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("scoreboard_empty", DW'(sb.size()), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
